// File: rtl/inv_mix_column_iter.sv
// AES InvMixColumns over a 128-bit row-major state, one column per cycle.
// Latency: 4 cycles from acceptance to out_valid (II of 6 with immediate drain).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module inv_mix_column_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t         fsm_q;
  fsm_t         fsm_nxt;
  logic [1:0]   col;
  logic [127:0] data_q;
  logic [127:0] result_q;
  logic [7:0]   col_in  [4];
  logic [7:0]   col_out [4];

  // GF(2^8) multiply by x, reduced by 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 0x09 = x8 ^ x1
  function automatic logic [7:0] mul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  // 0x0b = x8 ^ x2 ^ x1
  function automatic logic [7:0] mul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  // 0x0d = x8 ^ x4 ^ x1
  function automatic logic [7:0] mul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  // 0x0e = x8 ^ x4 ^ x2
  function automatic logic [7:0] mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    fsm_nxt   = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = BUSY;
      end
      BUSY: begin
        if (col == 2'd3) fsm_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Pick the four bytes of the current column out of the captured state
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      col_in[r] = data_q[127 - 8*(r*4 + int'(col)) -: 8];
    end
  end

  // One column of the InvMixColumns matrix: 16 constant products
  always_comb begin
    col_out[0] = mul0e(col_in[0]) ^ mul0b(col_in[1]) ^ mul0d(col_in[2]) ^ mul09(col_in[3]);
    col_out[1] = mul09(col_in[0]) ^ mul0e(col_in[1]) ^ mul0b(col_in[2]) ^ mul0d(col_in[3]);
    col_out[2] = mul0d(col_in[0]) ^ mul09(col_in[1]) ^ mul0e(col_in[2]) ^ mul0b(col_in[3]);
    col_out[3] = mul0b(col_in[0]) ^ mul0d(col_in[1]) ^ mul09(col_in[2]) ^ mul0e(col_in[3]);
  end

  // Capture on accept, then fill the result one column per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= 2'd0;
      data_q   <= 128'h0;
      result_q <= 128'h0;
    end else if (fsm_q == IDLE && in_valid) begin
      data_q <= in_data;
      col    <= 2'd0;
    end else if (fsm_q == BUSY) begin
      for (int r = 0; r < 4; r++) begin
        result_q[127 - 8*(r*4 + int'(col)) -: 8] <= col_out[r];
      end
      col <= col + 2'd1;
    end
  end

  assign out_data = result_q;

endmodule

// File: doc/inv_mix_column_iter.md
INV_MIX_COLUMN_ITER -- requirements
Module: inv_mix_column_iter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (asserted low, async assert, sync deassert supplied externally).
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
  clk        in   1    clock
  rst_n      in   1    async active-low reset
  in_valid   in   1    in_data holds a valid state
  in_ready   out  1    block can accept a state
  in_data    in   128  AES state, row-major, byte r*4+c at bits [127-8*(r*4+c) -: 8]
  out_valid  out  1    out_data holds a result
  out_ready  in   1    consumer accepts the result
  out_data   out  128  InvMixColumns(in_data), same byte layout
REQ-003 The byte layout SHALL match mix_column exactly, so that inv_mix_column_iter(mix_column(x)) == x for every x.

Function
REQ-004 Each result byte SHALL be out[r][c] = XOR over k of M[r][k] * in[k][c] in GF(2^8) with reduction polynomial 0x11B, where M rows are {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
REQ-005 The datapath SHALL process exactly one column (4 bytes, 16 GF products) per cycle; it SHALL NOT instantiate 64 parallel multipliers.
REQ-006 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-007 In IDLE, in_ready=1; on in_valid&&in_ready, the block SHALL capture in_data into a 128-bit state register, clear the 2-bit column counter col to 0, and enter BUSY.
REQ-008 In BUSY, each cycle SHALL compute column col and write it into the result register; col SHALL increment, and on col==3 the FSM SHALL enter DONE (col wraps to 0).
REQ-009 In DONE, out_valid=1 and out_data=result register; on out_ready=1 the FSM SHALL return to IDLE.
REQ-010 Latency SHALL be 4 cycles: out_valid rises on the 5th rising edge counting the accepting edge as edge 1.
REQ-011 in_ready SHALL be 1 only in IDLE; in_valid in BUSY or DONE SHALL be ignored with no state change.
REQ-012 out_data SHALL remain stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-013 When DONE and out_ready=1 coincide with a new in_valid, the new state SHALL NOT be accepted that cycle; it is accepted in the following IDLE cycle, giving a 6-cycle minimum initiation interval.
REQ-014 out_valid SHALL be 0 in IDLE and BUSY; out_data is don't-care there but SHALL NOT contain X after reset.
REQ-015 All GF constant multiplies SHALL be built from xtime chains (x2, x4, x8 plus XOR); no lookup tables.

Reset
REQ-016 On rst_n=0, asynchronously: state=IDLE, col=0, out_valid=0, in_ready=1 (while rst_n=0 and after release), and state/result registers =128'h0.
REQ-017 A reset asserted during BUSY or DONE SHALL abort the operation; no partial result SHALL ever be presented with out_valid=1.

Verification
REQ-018 Known vector: in_data=128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6 -> out_data=128'hdbf201c6_130a01c6_532201c6_455c01c6, with out_valid on the 5th edge after acceptance.
REQ-019 Round-trip: 1000 random x fed through mix_column, then inv_mix_column_iter -> out_data==x every time; in_ready/out_ready are randomly toggled.
REQ-020 Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 -> out_data stable, in_ready=0, no second capture; release -> IDLE next cycle, then accept.
REQ-021 Reset mid-op: accept 128'h0101..01, assert rst_n=0 on BUSY cycle 2 -> out_valid=0, in_ready=1, result=0; after release a new vector completes correctly.
REQ-022 Uniform columns: in_data=128'hc6c6...c6 -> out_data=128'hc6c6...c6; in_data=0 -> out_data=0.
